rx_pfc_pause: RTL and testbench
===============================

Name: rx_pfc_pause

Overview:
- Receive-side MAC-control parser on the 64-bit RX AXIS path after CRC check.
- Decodes both 802.3x link PAUSE (opcode 0x0001) and 802.1Qbb priority flow control (PFC, opcode 0x0101).
- Keeps one pause timer per traffic class and drives per-class pause-active flags to the TX scheduler.
- Can mark consumed control frames as bad (tuser_o=0) so downstream drops them.

Parameters:
- NUM_CLASSES, 8, number of priority classes tracked (1..8); PFC classes >= NUM_CLASSES are ignored.
- QUANTA_W, 16, pause timer width in quanta; load values are truncated to this width.
- STAT_W, 16, width of frame statistics counters.

Ports:
- clk  in  1  core clock (156.25 MHz nominal).
- rst  in  1  reset; asynchronous, active-high.
- tdata_i  in  64  RX AXIS data; byte 0 of frame in [7:0].
- tkeep_i  in  8  byte enables; informational only, not used for decode.
- tvalid_i  in  1  beat valid; no tready, module never stalls.
- tlast_i  in  1  end of frame.
- tuser_i  in  1  1 = good CRC.
- tuser_o  out  1  tuser_i, or forced 0 on last beat of consumed control frame.
- cfg_rx_pause_enable  in  1  enables 802.3x PAUSE decode and all timers.
- cfg_pfc_enable  in  1  enables PFC decode.
- cfg_drop_ctrl  in  1  force tuser_o=0 on control frames.
- cfg_sub_quanta_count  in  8  clocks per quanta; 0 treated as 1.
- rx_pause_active  out  NUM_CLASSES  bit c = class c paused (timer c > 0).
- stat_pause_frames  out  STAT_W  count of applied PAUSE frames, wraps.
- stat_pfc_frames  out  STAT_W  count of applied PFC frames, wraps.

Behaviour:
- Reset: all timers 0, rx_pause_active 0, stats 0, parser in S_IDLE, quanta prescaler 0. Upstream must be idle at reset release.
- tuser_o is combinational from tuser_i. It is forced 0 only when all of the following hold: tvalid_i, tlast_i, cfg_drop_ctrl, and parser has matched DA and ET (state S_PAY0..S_EOP).
- Parser states advance only on tvalid_i beats:
  - S_IDLE (SOP beat): DA tdata_i[47:0] == 01:80:C2:00:00:01 (byte order as on wire) -> S_HDR; else -> S_SKIP.
  - S_HDR: ET {[39:32],[47:40]} == 0x8808 -> latch opcode {[55:48],[63:56]}, -> S_PAY0; else -> S_SKIP.
  - S_PAY0:
    - opcode 0x0001 and cfg_rx_pause_enable: latch quanta {[7:0],[15:8]}, -> S_EOP.
    - opcode 0x0101 and cfg_pfc_enable: latch enable vector [15:8], time0 {[23:16],[31:24]}, time1, time2 -> S_PAY1.
    - otherwise -> S_CTRL (control frame, no action).
  - S_PAY1: latch time3..time6 from bytes 24..31 -> S_PAY2.
  - S_PAY2: latch time7 from bytes 32..33 -> S_EOP.
  - S_EOP, S_CTRL, S_SKIP: wait for tlast_i -> S_IDLE.
  - tlast_i in any state returns to S_IDLE. tlast before S_EOP (runt) = abort, no timer update.
- Apply happens at the S_EOP beat with tlast_i && tuser_i; the registered update is visible the next cycle.
  - PAUSE: all NUM_CLASSES timers <= quanta; stat_pause_frames++.
  - PFC: for each c < NUM_CLASSES with enable bit c set, timer c <= time_c; stat_pfc_frames++. Classes with a clear enable bit are unchanged.
  - A load value of 0 clears the timer (immediate resume next cycle).
  - Bad CRC (tuser_i=0) at EOP: no update, no stat increment.
- Quanta tick:
  - Shared prescaler counts 0..N-1 (N = max(cfg_sub_quanta_count,1)) while cfg_rx_pause_enable.
  - tick is asserted on the cycle the prescaler equals N-1; the prescaler then wraps to 0.
  - Each nonzero timer decrements on tick. Timers saturate at 0.
  - Load and tick in the same cycle: load wins.
  - Quantization error is at most 1 quanta.
- cfg_rx_pause_enable = 0: all timers and the prescaler are held at 0, and parsing of both opcodes is suppressed.
- cfg changes mid-frame take effect at the next beat evaluated.
- rx_pause_active[c] = (timer c != 0), registered-state derived, no extra latency.

Decomposition:
- Package rx_pause_pkg holds:
  - constants CTRL_DA, CTRL_ET=0x8808, OP_PAUSE=0x0001, OP_PFC=0x0101;
  - parser state enum.
- Sub-module pause_class_timer, instantiated NUM_CLASSES times.
  - Ports: clk, rst, enable, tick, load, load_val[QUANTA_W], active.
  - Holds one down-counter.

Test Plan:
- PAUSE frame, quanta 0x0010, N=8, good CRC -> all rx_pause_active=0xFF from the cycle after EOP for exactly 128 clocks ±8 (one quanta of prescaler phase); stat_pause_frames=1; tuser_o=0 on last beat.
- PFC frame, enable=0x05, time0=3, time2=0x100, N=1 -> bit0 high 3 cycles, bit2 high 256 cycles, others 0; stat_pfc_frames=1.
- Same PAUSE frame with tuser_i=0 at EOP -> no timer change, stats unchanged, tuser_o=0.
- PAUSE quanta 0 while class timers are running at 50 -> all bits clear the cycle after EOP.
- Runt control frame (tlast on HDR beat), then a normal data frame with DA 01:80:C2:00:00:01 but ET 0x0800 -> no updates, tuser_o follows tuser_i.
- Assert rst mid-pause with timers at 200, and separately toggle cfg_rx_pause_enable to 0 -> rx_pause_active=0 immediately (async) and all timers read 0 after release.

Source files
------------

// File: rtl/rx_pfc_pause_pkg.sv
// Shared constants and parser state encoding for the RX MAC-control
// PAUSE / PFC decoder.
package rx_pause_pkg;

  // Reserved MAC-control multicast 01:80:C2:00:00:01, packed with wire byte 0 in [7:0]
  localparam logic [47:0] CTRL_DA  = 48'h0100_00C2_8001;
  localparam logic [15:0] CTRL_ET  = 16'h8808;
  localparam logic [15:0] OP_PAUSE = 16'h0001;
  localparam logic [15:0] OP_PFC   = 16'h0101;

  // S_PAY0..S_EOP are contiguous so "control frame matched" is a range test
  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_HDR  = 3'd1,
    S_SKIP = 3'd2,
    S_PAY0 = 3'd3,
    S_PAY1 = 3'd4,
    S_PAY2 = 3'd5,
    S_CTRL = 3'd6,
    S_EOP  = 3'd7
  } parse_state_e;

  // Two wire bytes (first byte in [7:0]) to a big-endian 16-bit field
  function automatic logic [15:0] be16(input logic [15:0] w);
    return {w[7:0], w[15:8]};
  endfunction

endpackage

// File: rtl/rx_pfc_pause_if.sv
// 64-bit RX AXIS beat interface (no tready) with the CRC-status return path.
interface rx_pfc_pause_if;
  logic [63:0] tdata_i;
  logic [7:0]  tkeep_i;
  logic        tvalid_i;
  logic        tlast_i;
  logic        tuser_i;
  logic        tuser_o;

  modport master (
    output tdata_i, tkeep_i, tvalid_i, tlast_i, tuser_i,
    input  tuser_o
  );

  modport slave (
    input  tdata_i, tkeep_i, tvalid_i, tlast_i, tuser_i,
    output tuser_o
  );
endinterface

// File: rtl/rx_pfc_pause_timer.sv
// One per-class pause down-counter: load wins over tick, saturates at zero.
module pause_class_timer #(
  parameter int QUANTA_W = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                enable,
  input  logic                tick,
  input  logic                load,
  input  logic [QUANTA_W-1:0] load_val,
  output logic                active
);

  logic [QUANTA_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (!enable)
      cnt_d = '0;
    else if (load)
      cnt_d = load_val;
    else if (tick && (cnt_q != '0))
      cnt_d = cnt_q - QUANTA_W'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  assign active = (cnt_q != '0);

endmodule

// File: rtl/rx_pfc_pause.sv
// RX MAC-control parser: decodes 802.3x PAUSE and 802.1Qbb PFC frames and
// keeps per-class pause timers for the TX scheduler.
module rx_pfc_pause
  import rx_pause_pkg::*;
#(
  parameter int NUM_CLASSES = 8,
  parameter int QUANTA_W    = 16,
  parameter int STAT_W      = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  rx_pfc_pause_if.slave          axis,
  input  logic                   cfg_rx_pause_enable,
  input  logic                   cfg_pfc_enable,
  input  logic                   cfg_drop_ctrl,
  input  logic [7:0]             cfg_sub_quanta_count,
  output logic [NUM_CLASSES-1:0] rx_pause_active,
  output logic [STAT_W-1:0]      stat_pause_frames,
  output logic [STAT_W-1:0]      stat_pfc_frames
);

  parse_state_e      state_q, state_d;
  logic [15:0]       opcode_q, opcode_d;
  logic [15:0]       quanta_q, quanta_d;
  logic [7:0]        pfc_en_q, pfc_en_d;
  logic [7:0][15:0]  time_q, time_d;
  logic              is_pfc_q, is_pfc_d;
  logic [STAT_W-1:0] stat_pause_q, stat_pause_d;
  logic [STAT_W-1:0] stat_pfc_q, stat_pfc_d;
  logic [7:0]        presc_q, presc_d;

  logic       ctrl_match;
  logic       at_eop;
  logic       apply_pause;
  logic       apply_pfc;
  logic [7:0] presc_max;
  logic       tick;
  logic       unused_tkeep;

  assign unused_tkeep = ^axis.tkeep_i;

  always_comb begin
    state_d  = state_q;
    opcode_d = opcode_q;
    quanta_d = quanta_q;
    pfc_en_d = pfc_en_q;
    time_d   = time_q;
    is_pfc_d = is_pfc_q;
    if (axis.tvalid_i) begin
      unique case (state_q)
        S_IDLE: state_d = (axis.tdata_i[47:0] == CTRL_DA) ? S_HDR : S_SKIP;
        S_HDR: begin
          if (be16(axis.tdata_i[47:32]) == CTRL_ET) begin
            opcode_d = be16(axis.tdata_i[63:48]);
            state_d  = S_PAY0;
          end else begin
            state_d  = S_SKIP;
          end
        end
        S_PAY0: begin
          if ((opcode_q == OP_PAUSE) && cfg_rx_pause_enable) begin
            quanta_d = be16(axis.tdata_i[15:0]);
            is_pfc_d = 1'b0;
            state_d  = S_EOP;
          end else if ((opcode_q == OP_PFC) && cfg_pfc_enable && cfg_rx_pause_enable) begin
            pfc_en_d  = axis.tdata_i[15:8];
            time_d[0] = be16(axis.tdata_i[31:16]);
            time_d[1] = be16(axis.tdata_i[47:32]);
            time_d[2] = be16(axis.tdata_i[63:48]);
            is_pfc_d  = 1'b1;
            state_d   = S_PAY1;
          end else begin
            state_d   = S_CTRL;
          end
        end
        S_PAY1: begin
          time_d[3] = be16(axis.tdata_i[15:0]);
          time_d[4] = be16(axis.tdata_i[31:16]);
          time_d[5] = be16(axis.tdata_i[47:32]);
          time_d[6] = be16(axis.tdata_i[63:48]);
          state_d   = S_PAY2;
        end
        S_PAY2: begin
          time_d[7] = be16(axis.tdata_i[15:0]);
          state_d   = S_EOP;
        end
        default: state_d = state_q;
      endcase
      // Any end of frame resynchronises; a runt never reaches the apply point
      if (axis.tlast_i) state_d = S_IDLE;
    end
  end

  assign ctrl_match  = (state_q >= S_PAY0);
  assign at_eop      = axis.tvalid_i && axis.tlast_i && (state_q == S_EOP);
  assign apply_pause = at_eop && axis.tuser_i && cfg_rx_pause_enable && !is_pfc_q;
  assign apply_pfc   = at_eop && axis.tuser_i && cfg_rx_pause_enable && cfg_pfc_enable && is_pfc_q;

  assign axis.tuser_o = axis.tuser_i &
                        ~(axis.tvalid_i & axis.tlast_i & cfg_drop_ctrl & ctrl_match);

  always_comb begin
    stat_pause_d = stat_pause_q;
    stat_pfc_d   = stat_pfc_q;
    if (apply_pause) stat_pause_d = stat_pause_q + STAT_W'(1);
    if (apply_pfc)   stat_pfc_d   = stat_pfc_q + STAT_W'(1);
  end

  // A programmed count of 0 behaves as 1 (tick every clock)
  assign presc_max = (cfg_sub_quanta_count == 8'd0) ? 8'd0 : cfg_sub_quanta_count - 8'd1;
  assign tick      = cfg_rx_pause_enable && (presc_q >= presc_max);

  always_comb begin
    presc_d = presc_q + 8'd1;
    if (!cfg_rx_pause_enable || tick) presc_d = 8'd0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= S_IDLE;
      stat_pause_q <= '0;
      stat_pfc_q   <= '0;
      presc_q      <= 8'd0;
    end else begin
      state_q      <= state_d;
      stat_pause_q <= stat_pause_d;
      stat_pfc_q   <= stat_pfc_d;
      presc_q      <= presc_d;
    end
  end

  always_ff @(posedge clk) begin
    opcode_q <= opcode_d;
    quanta_q <= quanta_d;
    pfc_en_q <= pfc_en_d;
    time_q   <= time_d;
    is_pfc_q <= is_pfc_d;
  end

  for (genvar c = 0; c < NUM_CLASSES; c++) begin : g_class
    logic                load_c;
    logic [QUANTA_W-1:0] load_val_c;

    assign load_c     = apply_pause || (apply_pfc && pfc_en_q[c]);
    assign load_val_c = apply_pfc ? QUANTA_W'(time_q[c]) : QUANTA_W'(quanta_q);

    pause_class_timer #(
      .QUANTA_W (QUANTA_W)
    ) u_timer (
      .clk      (clk),
      .rst      (rst),
      .enable   (cfg_rx_pause_enable),
      .tick     (tick),
      .load     (load_c),
      .load_val (load_val_c),
      .active   (rx_pause_active[c])
    );
  end

  assign stat_pause_frames = stat_pause_q;
  assign stat_pfc_frames   = stat_pfc_q;

endmodule

// File: tb/tb_rx_pfc_pause.sv
// Self-checking bench for rx_pfc_pause: PAUSE/PFC timing, CRC, runt and
// reset/enable scenarios with a per-beat tuser_o scoreboard.
module tb_rx_pfc_pause;

  logic        clk = 1'b0;
  logic        rst;
  logic        cfg_rx, cfg_pfc, cfg_drop;
  logic [7:0]  cfg_n;
  logic [7:0]  rx_pause_active;
  logic [15:0] stat_pause, stat_pfc;

  int         n_vec = 0;
  int         n_err = 0;
  bit         exp_q[$];
  logic [7:0] fb[64];
  int         act_cnt[8];
  logic [7:0] act_first;

  always #5 clk = ~clk;

  rx_pfc_pause_if axis_if();

  rx_pfc_pause #(.NUM_CLASSES(8), .QUANTA_W(16), .STAT_W(16)) dut (
    .clk                  (clk),
    .rst                  (rst),
    .axis                 (axis_if),
    .cfg_rx_pause_enable  (cfg_rx),
    .cfg_pfc_enable       (cfg_pfc),
    .cfg_drop_ctrl        (cfg_drop),
    .cfg_sub_quanta_count (cfg_n),
    .rx_pause_active      (rx_pause_active),
    .stat_pause_frames    (stat_pause),
    .stat_pfc_frames      (stat_pfc)
  );

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic build_frame(input logic [15:0] et, input logic [15:0] op);
    for (int i = 0; i < 64; i++) fb[i] = 8'h00;
    fb[0] = 8'h01; fb[1] = 8'h80; fb[2] = 8'hC2;
    fb[3] = 8'h00; fb[4] = 8'h00; fb[5] = 8'h01;
    for (int i = 6; i < 12; i++) fb[i] = 8'(8'h10 + i);
    fb[12] = et[15:8]; fb[13] = et[7:0];
    fb[14] = op[15:8]; fb[15] = op[7:0];
  endtask

  task automatic build_pause(input logic [15:0] q);
    build_frame(16'h8808, 16'h0001);
    fb[16] = q[15:8]; fb[17] = q[7:0];
  endtask

  task automatic build_pfc(input logic [7:0] en, input logic [7:0][15:0] t);
    build_frame(16'h8808, 16'h0101);
    fb[17] = en;
    for (int c = 0; c < 8; c++) begin
      fb[18 + 2*c] = t[c][15:8];
      fb[19 + 2*c] = t[c][7:0];
    end
  endtask

  // Drives nbeats of fb[]; ends just after the edge that samples the last beat
  task automatic send_frame(input int nbeats, input bit good);
    bit ctrl;
    bit e, got;
    ctrl = (fb[0] == 8'h01) && (fb[1] == 8'h80) && (fb[2] == 8'hC2) &&
           (fb[3] == 8'h00) && (fb[4] == 8'h00) && (fb[5] == 8'h01) &&
           (fb[12] == 8'h88) && (fb[13] == 8'h08) && (nbeats >= 3);
    for (int i = 0; i < nbeats; i++) begin
      @(posedge clk); #1;
      for (int j = 0; j < 8; j++) axis_if.tdata_i[8*j +: 8] = fb[8*i + j];
      axis_if.tkeep_i  = 8'hFF;
      axis_if.tvalid_i = 1'b1;
      axis_if.tlast_i  = (i == nbeats - 1);
      axis_if.tuser_i  = (i == nbeats - 1) ? good : 1'b1;
      exp_q.push_back(((i == nbeats - 1) && cfg_drop && ctrl) ? 1'b0 : axis_if.tuser_i);
      @(negedge clk);
      got = axis_if.tuser_o;
      e   = exp_q.pop_front();
      n_vec++;
      if (got !== e) begin
        n_err++;
        $display("FAIL tuser_o beat %0d of %0d: got %0b, want %0b", i, nbeats, got, e);
      end
    end
    @(posedge clk); #1;
    axis_if.tvalid_i = 1'b0;
    axis_if.tlast_i  = 1'b0;
    axis_if.tuser_i  = 1'b1;
  endtask

  task automatic measure(input int bound);
    int cyc;
    cyc = 0;
    for (int c = 0; c < 8; c++) act_cnt[c] = 0;
    @(negedge clk);
    act_first = rx_pause_active;
    while ((rx_pause_active != 8'h00) && (cyc < bound)) begin
      for (int c = 0; c < 8; c++) if (rx_pause_active[c]) act_cnt[c]++;
      cyc++;
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    cfg_rx = 1'b1; cfg_pfc = 1'b1; cfg_drop = 1'b1; cfg_n = 8'd8;
    axis_if.tdata_i = '0; axis_if.tkeep_i = '0;
    axis_if.tvalid_i = 1'b0; axis_if.tlast_i = 1'b0; axis_if.tuser_i = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    n_vec++;
    if (rx_pause_active !== 8'h00) begin n_err++; $display("FAIL reset active: got %h, want 00", rx_pause_active); end
    n_vec++;
    if (stat_pause !== 16'd0 || stat_pfc !== 16'd0) begin
      n_err++; $display("FAIL reset stats: got %0d/%0d, want 0/0", stat_pause, stat_pfc);
    end
    n_vec++;
    if (axis_if.tuser_o !== 1'b1) begin n_err++; $display("FAIL reset tuser_o: got %b, want 1", axis_if.tuser_o); end
  endtask

  task automatic test_pause();
    cfg_n = 8'd8; cfg_drop = 1'b1;
    build_pause(16'h0010);
    send_frame(8, 1'b1);
    measure(400);
    n_vec++;
    if (act_first !== 8'hFF) begin n_err++; $display("FAIL pause first: got %h, want ff", act_first); end
    n_vec++;
    if (act_cnt[0] < 120 || act_cnt[0] > 136) begin
      n_err++; $display("FAIL pause duration c0: got %0d, want 120..136", act_cnt[0]);
    end
    n_vec++;
    if (act_cnt[7] < 120 || act_cnt[7] > 136) begin
      n_err++; $display("FAIL pause duration c7: got %0d, want 120..136", act_cnt[7]);
    end
    n_vec++;
    if (stat_pause !== 16'd1 || stat_pfc !== 16'd0) begin
      n_err++; $display("FAIL pause stats: got %0d/%0d, want 1/0", stat_pause, stat_pfc);
    end
  endtask

  task automatic test_pfc();
    logic [7:0][15:0] t;
    cfg_n = 8'd1; cfg_drop = 1'b0;
    t = '0;
    t[0] = 16'd3; t[1] = 16'h0050; t[2] = 16'h0100;
    build_pfc(8'h05, t);
    send_frame(8, 1'b1);
    measure(1000);
    n_vec++;
    if (act_first !== 8'h05) begin n_err++; $display("FAIL pfc first: got %h, want 05", act_first); end
    n_vec++;
    if (act_cnt[0] !== 3) begin n_err++; $display("FAIL pfc c0 cycles: got %0d, want 3", act_cnt[0]); end
    n_vec++;
    if (act_cnt[1] !== 0) begin n_err++; $display("FAIL pfc c1 cycles: got %0d, want 0", act_cnt[1]); end
    n_vec++;
    if (act_cnt[2] !== 256) begin n_err++; $display("FAIL pfc c2 cycles: got %0d, want 256", act_cnt[2]); end
    n_vec++;
    if (stat_pfc !== 16'd1 || stat_pause !== 16'd1) begin
      n_err++; $display("FAIL pfc stats: got %0d/%0d, want 1/1", stat_pause, stat_pfc);
    end
  endtask

  task automatic test_bad_crc();
    cfg_n = 8'd8; cfg_drop = 1'b1;
    build_pause(16'h0010);
    send_frame(8, 1'b0);
    @(negedge clk);
    n_vec++;
    if (rx_pause_active !== 8'h00) begin n_err++; $display("FAIL badcrc active: got %h, want 00", rx_pause_active); end
    n_vec++;
    if (stat_pause !== 16'd1) begin n_err++; $display("FAIL badcrc stat: got %0d, want 1", stat_pause); end
  endtask

  task automatic test_pause_zero();
    cfg_n = 8'd8;
    build_pause(16'd50);
    send_frame(8, 1'b1);
    repeat (16) @(negedge clk);
    n_vec++;
    if (rx_pause_active !== 8'hFF) begin n_err++; $display("FAIL zero running: got %h, want ff", rx_pause_active); end
    build_pause(16'd0);
    send_frame(8, 1'b1);
    @(negedge clk);
    n_vec++;
    if (rx_pause_active !== 8'h00) begin n_err++; $display("FAIL zero clear: got %h, want 00", rx_pause_active); end
    n_vec++;
    if (stat_pause !== 16'd3) begin n_err++; $display("FAIL zero stat: got %0d, want 3", stat_pause); end
  endtask

  task automatic test_runt_and_data();
    cfg_drop = 1'b1;
    build_pause(16'h0020);
    send_frame(2, 1'b1);
    send_frame(3, 1'b1);
    build_frame(16'h0800, 16'h0001);
    fb[16] = 8'h00; fb[17] = 8'h20;
    send_frame(8, 1'b1);
    send_frame(8, 1'b0);
    @(negedge clk);
    n_vec++;
    if (rx_pause_active !== 8'h00) begin n_err++; $display("FAIL runt active: got %h, want 00", rx_pause_active); end
    n_vec++;
    if (stat_pause !== 16'd3 || stat_pfc !== 16'd1) begin
      n_err++; $display("FAIL runt stats: got %0d/%0d, want 3/1", stat_pause, stat_pfc);
    end
  endtask

  task automatic test_disable_parse();
    logic [7:0][15:0] t;
    cfg_rx = 1'b0; cfg_pfc = 1'b1; cfg_drop = 1'b1;
    build_pause(16'h0010);
    send_frame(8, 1'b1);
    t = '0; t[3] = 16'h0040;
    build_pfc(8'h08, t);
    send_frame(8, 1'b1);
    @(negedge clk);
    n_vec++;
    if (rx_pause_active !== 8'h00) begin n_err++; $display("FAIL disabled active: got %h, want 00", rx_pause_active); end
    n_vec++;
    if (stat_pause !== 16'd3 || stat_pfc !== 16'd1) begin
      n_err++; $display("FAIL disabled stats: got %0d/%0d, want 3/1", stat_pause, stat_pfc);
    end
    cfg_rx = 1'b1;
  endtask

  task automatic test_async_reset();
    cfg_n = 8'd8;
    build_pause(16'd200);
    send_frame(8, 1'b1);
    repeat (20) @(negedge clk);
    n_vec++;
    if (rx_pause_active !== 8'hFF) begin n_err++; $display("FAIL arst pre: got %h, want ff", rx_pause_active); end
    #2 rst = 1'b1;
    #1;
    n_vec++;
    if (rx_pause_active !== 8'h00) begin n_err++; $display("FAIL arst async: got %h, want 00", rx_pause_active); end
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    repeat (4) @(negedge clk);
    n_vec++;
    if (rx_pause_active !== 8'h00) begin n_err++; $display("FAIL arst post: got %h, want 00", rx_pause_active); end
    n_vec++;
    if (stat_pause !== 16'd0 || stat_pfc !== 16'd0) begin
      n_err++; $display("FAIL arst stats: got %0d/%0d, want 0/0", stat_pause, stat_pfc);
    end
  endtask

  task automatic test_enable_toggle();
    cfg_n = 8'd8;
    build_pause(16'd200);
    send_frame(8, 1'b1);
    @(negedge clk);
    n_vec++;
    if (rx_pause_active !== 8'hFF) begin n_err++; $display("FAIL toggle pre: got %h, want ff", rx_pause_active); end
    cfg_rx = 1'b0;
    @(negedge clk);
    n_vec++;
    if (rx_pause_active !== 8'h00) begin n_err++; $display("FAIL toggle off: got %h, want 00", rx_pause_active); end
    cfg_rx = 1'b1;
    repeat (5) @(negedge clk);
    n_vec++;
    if (rx_pause_active !== 8'h00) begin n_err++; $display("FAIL toggle on: got %h, want 00", rx_pause_active); end
    n_vec++;
    if (stat_pause !== 16'd1) begin n_err++; $display("FAIL toggle stat: got %0d, want 1", stat_pause); end
  endtask

  initial begin
    test_reset();
    test_pause();
    test_pfc();
    test_bad_crc();
    test_pause_zero();
    test_runt_and_data();
    test_disable_parse();
    test_async_reset();
    test_enable_toggle();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
